// File: rtl/memory_stage_pkg.sv
// Shared encodings for the memory stage: result-select codes and FSM states.
package memory_stage_pkg;

  localparam int WORD_SIZE = 32;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  typedef enum logic {
    MS_IDLE     = 1'b0,
    MS_WAIT_RSP = 1'b1
  } msState_t;

  // A load is any op that selects memory data for writeback.
  function automatic logic isLoadOp(input logic memWrite, input logic [1:0] resultSrc);
    return !memWrite && (resultSrc == RESULT_MEM);
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory bus: valid/ready request channel plus a valid-only response channel.
interface memory_stage_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req_valid, we, addr, wdata,
    input  req_ready, rsp_valid, rdata
  );

  modport slave (
    input  req_valid, we, addr, wdata,
    output req_ready, rsp_valid, rdata
  );
endinterface

// File: rtl/memory_stage_mem_wb_reg.sv
// M/W pipeline register. A stall inserts a bubble (write enable cleared, other
// fields held) so a stalled instruction is never written back twice; kill lets
// the stage drop an instruction that faulted in memory.
module mem_wb_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              kill,
  input  logic              RegWriteM,
  input  logic [4:0]        RdM,
  input  logic [1:0]        ResultSrcM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] ReadDataM,
  input  logic [DATA_W-1:0] PCPlus4M,
  output logic              RegWriteW,
  output logic [4:0]        RdW,
  output logic [1:0]        ResultSrcW,
  output logic [DATA_W-1:0] ALUResultW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [DATA_W-1:0] PCPlus4W
);

  // Capture on advance, bubble on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteW  <= 1'b0;
      RdW        <= '0;
      ResultSrcW <= '0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
    end else if (stall) begin
      RegWriteW  <= 1'b0;
    end else begin
      RegWriteW  <= RegWriteM & ~kill;
      RdW        <= RdM;
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= ReadDataM;
      PCPlus4W   <= PCPlus4M;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: issues one data-memory request per load/store, stalls the
// pipeline while the access is outstanding, and feeds the W stage.
//
//   state       | meaning
//   MS_IDLE     | no access outstanding; requests are driven straight from M
//   MS_WAIT_RSP | load accepted, waiting for rsp_valid or the timeout
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DATA_W      = WORD_SIZE,
  parameter int RSP_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [DATA_W-1:0] PCPlus4M,
  input  logic [4:0]        RdM,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic [1:0]        ResultSrcM,
  memory_stage_if.master    dmem,
  output logic              StallM,
  output logic              RegWriteW,
  output logic [4:0]        RdW,
  output logic [DATA_W-1:0] ResultW,
  output logic              mem_err
);

  localparam int CNT_W = $clog2(RSP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_TIMEOUT - 1);

  msState_t          state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic              isLoad, memOp, misaligned;
  logic              stallRaw, reqRaw, errRaw, killW;
  logic              regWriteQ;
  logic [1:0]        ResultSrcW;
  logic [DATA_W-1:0] ALUResultW, ReadDataW, PCPlus4W;

  assign isLoad     = isLoadOp(MemWriteM, ResultSrcM);
  assign memOp      = MemWriteM | isLoad;
  assign misaligned = memOp & (|ALUResultM[1:0]);

  // State and timeout counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MS_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Next state, stall, request and error decode.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    stallRaw  = 1'b0;
    reqRaw    = 1'b0;
    errRaw    = 1'b0;
    killW     = 1'b0;
    case (state)
      MS_IDLE: begin
        cntNext = '0;
        if (misaligned) begin
          errRaw = 1'b1;
          killW  = 1'b1;
        end else if (MemWriteM) begin
          reqRaw   = 1'b1;
          stallRaw = ~dmem.req_ready;
        end else if (isLoad) begin
          reqRaw   = 1'b1;
          stallRaw = 1'b1;
          if (dmem.req_ready) stateNext = MS_WAIT_RSP;
        end
      end
      MS_WAIT_RSP: begin
        // A response in the timeout cycle still counts as good data.
        if (dmem.rsp_valid) begin
          stateNext = MS_IDLE;
        end else if (cnt == CNT_LAST) begin
          errRaw    = 1'b1;
          killW     = 1'b1;
          stateNext = MS_IDLE;
        end else begin
          stallRaw = 1'b1;
          cntNext  = cnt + CNT_W'(1);
        end
      end
      default: stateNext = MS_IDLE;
    endcase
  end

  assign StallM         = stallRaw & rst_n;
  assign dmem.req_valid = reqRaw & rst_n;
  assign mem_err        = errRaw & rst_n;
  assign dmem.we        = MemWriteM;
  assign dmem.addr      = ALUResultM;
  assign dmem.wdata     = WriteDataM;

  mem_wb_reg #(.DATA_W(DATA_W)) uMemWb (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (StallM),
    .kill       (killW),
    .RegWriteM  (RegWriteM),
    .RdM        (RdM),
    .ResultSrcM (ResultSrcM),
    .ALUResultM (ALUResultM),
    .ReadDataM  (dmem.rdata),
    .PCPlus4M   (PCPlus4M),
    .RegWriteW  (regWriteQ),
    .RdW        (RdW),
    .ResultSrcW (ResultSrcW),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .PCPlus4W   (PCPlus4W)
  );

  // x0 is hardwired, so never signal a write to it.
  assign RegWriteW = regWriteQ & (RdW != 5'd0);

  // Writeback select; the reserved code falls back to the ALU result.
  always_comb begin
    ResultW = ALUResultW;
    case (ResultSrcW)
      RESULT_MEM: ResultW = ReadDataW;
      RESULT_PC4: ResultW = PCPlus4W;
      default:    ResultW = ALUResultW;
    endcase
  end

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic        StallM, RegWriteW, mem_err;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  int          testsRun = 0;
  int          failCount = 0;
  int          hsCount = 0;

  memory_stage_if #(.DATA_W(32)) dmem ();

  memory_stage #(.DATA_W(32), .RSP_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .PCPlus4M   (PCPlus4M),
    .RdM        (RdM),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .dmem       (dmem.master),
    .StallM     (StallM),
    .RegWriteW  (RegWriteW),
    .RdW        (RdW),
    .ResultW    (ResultW),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && dmem.req_valid && dmem.req_ready) hsCount <= hsCount + 1;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic setOp(input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc4,
                       input logic [4:0] rd, input logic rw, input logic mw, input logic [1:0] src);
    ALUResultM = addr; WriteDataM = wdata; PCPlus4M = pc4;
    RdM = rd; RegWriteM = rw; MemWriteM = mw; ResultSrcM = src;
  endtask

  task automatic nop();
    setOp(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, RESULT_ALU);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    setOp(32'h100, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0, RESULT_MEM);
    dmem.req_ready = 1'b1; dmem.rsp_valid = 1'b0; dmem.rdata = 32'h0;
    @(negedge clk);
    checkVal("rst_stall", 32'(StallM), 32'd0);
    checkVal("rst_req", 32'(dmem.req_valid), 32'd0);
    checkVal("rst_regwrite", 32'(RegWriteW), 32'd0);
    checkVal("rst_rd", 32'(RdW), 32'd0);
    checkVal("rst_result", ResultW, 32'd0);
    checkVal("rst_err", 32'(mem_err), 32'd0);

    // ALU op
    step(); rst_n = 1'b1; dmem.req_ready = 1'b0;
    setOp(32'h1234, 32'h0, 32'h0, 5'd5, 1'b1, 1'b0, RESULT_ALU);
    @(negedge clk);
    checkVal("alu_stall", 32'(StallM), 32'd0);
    checkVal("alu_req", 32'(dmem.req_valid), 32'd0);
    step(); nop();
    @(negedge clk);
    checkVal("alu_regwrite", 32'(RegWriteW), 32'd1);
    checkVal("alu_rd", 32'(RdW), 32'd5);
    checkVal("alu_result", ResultW, 32'h1234);

    // PC+4 select, then a write to x0
    step(); setOp(32'h999, 32'h0, 32'h2004, 5'd1, 1'b1, 1'b0, RESULT_PC4);
    @(negedge clk);
    checkVal("pc4_stall", 32'(StallM), 32'd0);
    step(); setOp(32'h77, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, RESULT_ALU);
    @(negedge clk);
    checkVal("pc4_result", ResultW, 32'h2004);
    checkVal("pc4_regwrite", 32'(RegWriteW), 32'd1);
    step(); nop();
    @(negedge clk);
    checkVal("x0_regwrite", 32'(RegWriteW), 32'd0);
    checkVal("x0_result", ResultW, 32'h77);

    // Load, response three cycles after acceptance
    step(); setOp(32'h100, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0, RESULT_MEM); dmem.req_ready = 1'b1;
    @(negedge clk);
    checkVal("ld_req", 32'(dmem.req_valid), 32'd1);
    checkVal("ld_we", 32'(dmem.we), 32'd0);
    checkVal("ld_addr", dmem.addr, 32'h100);
    checkVal("ld_stall0", 32'(StallM), 32'd1);
    step(); dmem.req_ready = 1'b0;
    @(negedge clk);
    checkVal("ld_stall1", 32'(StallM), 32'd1);
    checkVal("ld_noreissue", 32'(dmem.req_valid), 32'd0);
    checkVal("ld_bubble", 32'(RegWriteW), 32'd0);
    step();
    @(negedge clk);
    checkVal("ld_stall2", 32'(StallM), 32'd1);
    step(); dmem.rsp_valid = 1'b1; dmem.rdata = 32'hDEADBEEF;
    @(negedge clk);
    checkVal("ld_stall3", 32'(StallM), 32'd0);
    step(); dmem.rsp_valid = 1'b0; nop();
    @(negedge clk);
    checkVal("ld_regwrite", 32'(RegWriteW), 32'd1);
    checkVal("ld_rd", 32'(RdW), 32'd7);
    checkVal("ld_result", ResultW, 32'hDEADBEEF);
    checkVal("ld_handshakes", 32'(hsCount), 32'd1);

    // Store with ready low for two cycles
    step(); setOp(32'h200, 32'hA5A5A5A5, 32'h0, 5'd0, 1'b0, 1'b1, RESULT_ALU); dmem.req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkVal("st_req", 32'(dmem.req_valid), 32'd1);
      checkVal("st_we", 32'(dmem.we), 32'd1);
      checkVal("st_addr", dmem.addr, 32'h200);
      checkVal("st_wdata", dmem.wdata, 32'hA5A5A5A5);
      checkVal("st_stall", 32'(StallM), 32'd1);
      checkVal("st_regwrite", 32'(RegWriteW), 32'd0);
      step();
    end
    dmem.req_ready = 1'b1;
    @(negedge clk);
    checkVal("st_done_stall", 32'(StallM), 32'd0);
    checkVal("st_done_req", 32'(dmem.req_valid), 32'd1);
    step(); nop(); dmem.req_ready = 1'b0;
    @(negedge clk);
    checkVal("st_after_regwrite", 32'(RegWriteW), 32'd0);
    checkVal("st_handshakes", 32'(hsCount), 32'd2);

    // Misaligned load
    step(); setOp(32'h103, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, RESULT_MEM); dmem.req_ready = 1'b1;
    @(negedge clk);
    checkVal("mis_req", 32'(dmem.req_valid), 32'd0);
    checkVal("mis_err", 32'(mem_err), 32'd1);
    checkVal("mis_stall", 32'(StallM), 32'd0);
    step(); nop(); dmem.req_ready = 1'b0;
    @(negedge clk);
    checkVal("mis_err_pulse", 32'(mem_err), 32'd0);
    checkVal("mis_regwrite", 32'(RegWriteW), 32'd0);
    checkVal("mis_handshakes", 32'(hsCount), 32'd2);

    // Load timeout (RSP_TIMEOUT = 4)
    step(); setOp(32'h300, 32'h0, 32'h0, 5'd10, 1'b1, 1'b0, RESULT_MEM); dmem.req_ready = 1'b1;
    @(negedge clk);
    checkVal("to_stall0", 32'(StallM), 32'd1);
    step(); dmem.req_ready = 1'b0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      checkVal("to_stall", 32'(StallM), 32'd1);
      checkVal("to_noerr", 32'(mem_err), 32'd0);
      step();
    end
    @(negedge clk);
    checkVal("to_err", 32'(mem_err), 32'd1);
    checkVal("to_release", 32'(StallM), 32'd0);
    step(); setOp(32'h55, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, RESULT_ALU);
    dmem.rsp_valid = 1'b1; dmem.rdata = 32'hBAD0BAD0;
    @(negedge clk);
    checkVal("to_regwrite", 32'(RegWriteW), 32'd0);
    checkVal("to_err_pulse", 32'(mem_err), 32'd0);
    checkVal("stale_stall", 32'(StallM), 32'd0);
    step(); dmem.rsp_valid = 1'b0; nop();
    @(negedge clk);
    checkVal("stale_regwrite", 32'(RegWriteW), 32'd1);
    checkVal("stale_result", ResultW, 32'h55);

    // Reset during WAIT_RSP, then a late response
    step(); setOp(32'h400, 32'h0, 32'h0, 5'd11, 1'b1, 1'b0, RESULT_MEM); dmem.req_ready = 1'b1;
    @(negedge clk);
    checkVal("rw_stall0", 32'(StallM), 32'd1);
    step(); dmem.req_ready = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkVal("rw_rst_regwrite", 32'(RegWriteW), 32'd0);
    checkVal("rw_rst_rd", 32'(RdW), 32'd0);
    checkVal("rw_rst_result", ResultW, 32'd0);
    checkVal("rw_rst_stall", 32'(StallM), 32'd0);
    step(); rst_n = 1'b1;
    setOp(32'h500, 32'h0, 32'h0, 5'd12, 1'b1, 1'b0, RESULT_MEM);
    dmem.rsp_valid = 1'b1; dmem.rdata = 32'h1111;
    @(negedge clk);
    checkVal("rw_idle_req", 32'(dmem.req_valid), 32'd1);
    checkVal("rw_idle_stall", 32'(StallM), 32'd1);
    step(); dmem.rsp_valid = 1'b0; dmem.req_ready = 1'b1;
    @(negedge clk);
    checkVal("rw_late_regwrite", 32'(RegWriteW), 32'd0);
    checkVal("rw_accept_stall", 32'(StallM), 32'd1);
    step(); dmem.req_ready = 1'b0; dmem.rsp_valid = 1'b1; dmem.rdata = 32'h12345678;
    @(negedge clk);
    checkVal("rw_rsp_stall", 32'(StallM), 32'd0);
    step(); dmem.rsp_valid = 1'b0; nop();
    @(negedge clk);
    checkVal("rw_regwrite", 32'(RegWriteW), 32'd1);
    checkVal("rw_rd", 32'(RdW), 32'd12);
    checkVal("rw_result", ResultW, 32'h12345678);
    checkVal("rw_handshakes", 32'(hsCount), 32'd5);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
